// File: rtl/arcade_ioctl_ctrl.sv
// arcade_ioctl_ctrl: ioctl download router, mod/DIP latches, core reset sequencer and coin pulse shaper.
module arcade_ioctl_ctrl #(
   parameter int NUM_DIP     = 8,
   parameter int MOD_COUNT   = 18,
   parameter int ROM_IDX     = 0,
   parameter int MOD_IDX     = 1,
   parameter int DIP_IDX     = 254,
   parameter int HOLD_CYCLES = 1024,
   parameter int NUM_COIN    = 2,
   parameter int COIN_PULSE  = 64
) (
   input  logic                   clk_sys,
   input  logic                   RESET_N,
   input  logic                   ioctl_download,
   input  logic                   ioctl_wr,
   input  logic [7:0]             ioctl_index,
   input  logic [24:0]            ioctl_addr,
   input  logic [7:0]             ioctl_dout,
   input  logic                   user_reset,
   input  logic [NUM_COIN-1:0]    coin_in,
   output logic                   rom_wr,
   output logic [15:0]            rom_addr,
   output logic [7:0]             rom_data,
   output logic [7:0]             mod_id,
   output logic [MOD_COUNT-1:0]   mod_onehot,
   output logic [8*NUM_DIP-1:0]   dip_flat,
   output logic                   dip_valid,
   output logic                   core_reset,
   output logic [NUM_COIN-1:0]    coin_out
);
   localparam int CW = $clog2(HOLD_CYCLES + 1);
   localparam int PW = $clog2(COIN_PULSE + 1);
   localparam logic [CW-1:0] HOLD_INIT = CW'(HOLD_CYCLES - 1);

   typedef enum logic [1:0] {RUN, LOAD, HOLD} state_t;

   state_t          state, state_n;
   logic [CW-1:0]   cnt, cnt_n;
   logic [7:0]      dip [NUM_DIP];
   logic            dl_q;
   logic [NUM_COIN-1:0] coin_q;
   logic [PW-1:0]   ccnt [NUM_COIN];

   wire rom_sel = ioctl_index == 8'(ROM_IDX);
   wire mod_sel = ioctl_index == 8'(MOD_IDX);
   wire dip_sel = ioctl_index == 8'(DIP_IDX);

   always_ff @(posedge clk_sys or negedge RESET_N) begin
      if (!RESET_N) begin
         rom_wr     <= 1'b0;
         rom_addr   <= '0;
         rom_data   <= '0;
         mod_id     <= '0;
         mod_onehot <= MOD_COUNT'(1);
         dip_valid  <= 1'b0;
         dl_q       <= 1'b0;
         for (int k = 0; k < NUM_DIP; k++) dip[k] <= 8'hFF;
      end else begin
         rom_wr <= ioctl_wr & rom_sel;
         if (ioctl_wr & rom_sel) begin
            rom_addr <= ioctl_addr[15:0];
            rom_data <= ioctl_dout;
         end
         if (ioctl_wr & mod_sel) mod_id <= ioctl_dout;
         mod_onehot <= (mod_id < 8'(MOD_COUNT)) ? MOD_COUNT'(1) << mod_id : '0;
         // exact address compare so out-of-range bytes never alias onto the bank
         for (int k = 0; k < NUM_DIP; k++)
            if (ioctl_wr & dip_sel & (ioctl_addr == 25'(k))) dip[k] <= ioctl_dout;
         dl_q <= ioctl_download;
         if (dl_q & ~ioctl_download & dip_sel) dip_valid <= 1'b1;
      end
   end

   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      if (ioctl_download & rom_sel) state_n = LOAD;
      else if (state == LOAD) begin
         if (!ioctl_download) begin
            state_n = HOLD;
            cnt_n   = HOLD_INIT;
         end
      end else if (user_reset) begin
         state_n = HOLD;
         cnt_n   = HOLD_INIT;
      end else if (state == HOLD) begin
         if (cnt == '0) state_n = RUN;
         else cnt_n = cnt - CW'(1);
      end
   end

   // core_reset tracks the next state so its high time equals the HOLD length
   always_ff @(posedge clk_sys or negedge RESET_N) begin
      if (!RESET_N) begin
         state      <= HOLD;
         cnt        <= HOLD_INIT;
         core_reset <= 1'b1;
      end else begin
         state      <= state_n;
         cnt        <= cnt_n;
         core_reset <= state_n != RUN;
      end
   end

   always_ff @(posedge clk_sys or negedge RESET_N) begin
      if (!RESET_N) begin
         coin_q <= '0;
         for (int c = 0; c < NUM_COIN; c++) ccnt[c] <= '0;
      end else begin
         coin_q <= coin_in;
         for (int c = 0; c < NUM_COIN; c++)
            ccnt[c] <= core_reset ? '0 :
                       (ccnt[c] != '0) ? ccnt[c] - PW'(1) :
                       (coin_in[c] & ~coin_q[c]) ? PW'(COIN_PULSE) : '0;
      end
   end

   always_comb begin
      coin_out = '0;
      for (int c = 0; c < NUM_COIN; c++) coin_out[c] = (ccnt[c] != '0) & ~core_reset;
   end

   for (genvar k = 0; k < NUM_DIP; k++) begin : g_dip
      assign dip_flat[8*k +: 8] = dip[k];
   end
endmodule

// File: tb/tb_arcade_ioctl_ctrl.sv
// tb_arcade_ioctl_ctrl: directed vector table plus hand sequences for reset, download and coin timing.
module tb_arcade_ioctl_ctrl;
   localparam int HOLD = 1024;
   localparam int PULSE = 64;

   logic        clk_sys = 1'b0;
   logic        RESET_N;
   logic        ioctl_download, ioctl_wr, user_reset;
   logic [7:0]  ioctl_index, ioctl_dout;
   logic [24:0] ioctl_addr;
   logic [1:0]  coin_in;
   logic        rom_wr, dip_valid, core_reset;
   logic [15:0] rom_addr;
   logic [7:0]  rom_data, mod_id;
   logic [17:0] mod_onehot;
   logic [63:0] dip_flat;
   logic [1:0]  coin_out;

   int total = 0;
   int bad = 0;

   arcade_ioctl_ctrl dut (
      .clk_sys(clk_sys), .RESET_N(RESET_N), .ioctl_download(ioctl_download),
      .ioctl_wr(ioctl_wr), .ioctl_index(ioctl_index), .ioctl_addr(ioctl_addr),
      .ioctl_dout(ioctl_dout), .user_reset(user_reset), .coin_in(coin_in),
      .rom_wr(rom_wr), .rom_addr(rom_addr), .rom_data(rom_data), .mod_id(mod_id),
      .mod_onehot(mod_onehot), .dip_flat(dip_flat), .dip_valid(dip_valid),
      .core_reset(core_reset), .coin_out(coin_out)
   );

   always #5 clk_sys = ~clk_sys;

   typedef struct {
      logic [7:0]  idx;
      logic [24:0] addr;
      logic [7:0]  dout;
      logic        e_wr;
      logic [15:0] e_addr;
      logic [7:0]  e_data;
      logic [7:0]  e_mod;
      logic [17:0] e_oh;
      logic [63:0] e_dip;
   } vec_t;

   vec_t vec [11];

   task automatic tick();
      @(posedge clk_sys);
      #1;
   endtask

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic count_reset(output int n);
      n = 0;
      while (core_reset && n < 5000) begin
         tick();
         n++;
      end
   endtask

   initial begin
      int n, h0, h1;
      logic [7:0] rom_bytes [4];
      rom_bytes = '{8'hA5, 8'h5A, 8'h3C, 8'hC3};
      vec[0]  = '{8'd1,   25'd0,       8'h0F, 1'b0, 16'h0003, 8'hC3, 8'h0F, 18'h08000, 64'hFFFF_FFFF_FFFF_FFFF};
      vec[1]  = '{8'd1,   25'd0,       8'h20, 1'b0, 16'h0003, 8'hC3, 8'h20, 18'h00000, 64'hFFFF_FFFF_FFFF_FFFF};
      vec[2]  = '{8'd1,   25'd0,       8'h11, 1'b0, 16'h0003, 8'hC3, 8'h11, 18'h20000, 64'hFFFF_FFFF_FFFF_FFFF};
      vec[3]  = '{8'd1,   25'd0,       8'h12, 1'b0, 16'h0003, 8'hC3, 8'h12, 18'h00000, 64'hFFFF_FFFF_FFFF_FFFF};
      vec[4]  = '{8'd1,   25'd0,       8'h00, 1'b0, 16'h0003, 8'hC3, 8'h00, 18'h00001, 64'hFFFF_FFFF_FFFF_FFFF};
      vec[5]  = '{8'd0,   25'h1_2345,  8'h77, 1'b1, 16'h2345, 8'h77, 8'h00, 18'h00001, 64'hFFFF_FFFF_FFFF_FFFF};
      vec[6]  = '{8'd254, 25'd0,       8'h3C, 1'b0, 16'h2345, 8'h77, 8'h00, 18'h00001, 64'hFFFF_FFFF_FFFF_FF3C};
      vec[7]  = '{8'd254, 25'd9,       8'h11, 1'b0, 16'h2345, 8'h77, 8'h00, 18'h00001, 64'hFFFF_FFFF_FFFF_FF3C};
      vec[8]  = '{8'd254, 25'd7,       8'hAB, 1'b0, 16'h2345, 8'h77, 8'h00, 18'h00001, 64'hABFF_FFFF_FFFF_FF3C};
      vec[9]  = '{8'd254, 25'd8,       8'h55, 1'b0, 16'h2345, 8'h77, 8'h00, 18'h00001, 64'hABFF_FFFF_FFFF_FF3C};
      vec[10] = '{8'd2,   25'd0,       8'h99, 1'b0, 16'h2345, 8'h77, 8'h00, 18'h00001, 64'hABFF_FFFF_FFFF_FF3C};

      RESET_N = 1'b0; ioctl_download = 1'b0; ioctl_wr = 1'b0; user_reset = 1'b0;
      ioctl_index = '0; ioctl_addr = '0; ioctl_dout = '0; coin_in = '0;
      tick(); tick();
      check("rst core_reset", core_reset, 1);
      check("rst rom_wr", rom_wr, 0);
      check("rst mod_onehot", mod_onehot, 1);
      check("rst dip_flat", dip_flat, 64'hFFFF_FFFF_FFFF_FFFF);
      check("rst dip_valid", dip_valid, 0);
      check("rst coin_out", coin_out, 0);
      RESET_N = 1'b1;
      count_reset(n);
      check("post-reset hold length", n, HOLD);

      // ROM download
      ioctl_download = 1'b1; ioctl_index = 8'd0;
      tick();
      check("load core_reset", core_reset, 1);
      for (int i = 0; i < 4; i++) begin
         ioctl_wr = 1'b1; ioctl_addr = 25'(i); ioctl_dout = rom_bytes[i];
         tick();
         ioctl_wr = 1'b0;
         check($sformatf("rom%0d rom_wr", i), rom_wr, 1);
         check($sformatf("rom%0d rom_addr", i), rom_addr, 64'(i));
         check($sformatf("rom%0d rom_data", i), rom_data, rom_bytes[i]);
         tick();
         check($sformatf("rom%0d rom_wr drop", i), rom_wr, 0);
      end
      check("load core_reset held", core_reset, 1);
      ioctl_download = 1'b0;
      tick();
      check("hold entry core_reset", core_reset, 1);
      count_reset(n);
      check("post-load hold length", n, HOLD);

      // table vectors, download idle
      for (int i = 0; i < 11; i++) begin
         ioctl_wr = 1'b1; ioctl_index = vec[i].idx; ioctl_addr = vec[i].addr; ioctl_dout = vec[i].dout;
         tick();
         ioctl_wr = 1'b0;
         check($sformatf("vec%0d rom_wr", i), rom_wr, vec[i].e_wr);
         check($sformatf("vec%0d rom_addr", i), rom_addr, vec[i].e_addr);
         check($sformatf("vec%0d rom_data", i), rom_data, vec[i].e_data);
         check($sformatf("vec%0d mod_id", i), mod_id, vec[i].e_mod);
         tick();
         check($sformatf("vec%0d mod_onehot", i), mod_onehot, vec[i].e_oh);
         check($sformatf("vec%0d dip_flat", i), dip_flat, vec[i].e_dip);
         check($sformatf("vec%0d rom_wr drop", i), rom_wr, 0);
      end
      check("table core_reset", core_reset, 0);

      // DIP and MOD downloads never touch the reset sequencer
      ioctl_download = 1'b1; ioctl_index = 8'd254;
      tick();
      check("dip dl core_reset", core_reset, 0);
      check("dip_valid before fall", dip_valid, 0);
      ioctl_download = 1'b0;
      tick();
      check("dip_valid after fall", dip_valid, 1);
      check("dip fall core_reset", core_reset, 0);
      ioctl_download = 1'b1; ioctl_index = 8'd1;
      tick(); tick();
      check("mod dl core_reset", core_reset, 0);
      ioctl_download = 1'b0;
      tick();
      check("mod fall core_reset", core_reset, 0);
      check("dip_valid sticky", dip_valid, 1);

      // user_reset and restart mid-HOLD
      user_reset = 1'b1; tick(); user_reset = 1'b0;
      check("user_reset core_reset", core_reset, 1);
      repeat (500) tick();
      check("mid-hold core_reset", core_reset, 1);
      user_reset = 1'b1; tick(); user_reset = 1'b0;
      count_reset(n);
      check("restarted hold length", n, HOLD);

      // coin held 500 cycles gives one pulse
      h0 = 0; h1 = 0;
      coin_in[0] = 1'b1;
      for (int i = 0; i < 500; i++) begin
         tick();
         if (coin_out[0]) h0++;
         if (coin_out[1]) h1++;
      end
      check("coin held pulse length", h0, PULSE);
      check("coin idle channel", h1, 0);
      coin_in[0] = 1'b0;
      h0 = 0;
      repeat (100) begin tick(); if (coin_out[0]) h0++; end
      check("coin release no pulse", h0, 0);

      // re-press during pulse ignored
      h0 = 0; h1 = 0;
      for (int i = 0; i < 200; i++) begin
         coin_in[1] = (i == 0 || i == 30);
         tick();
         if (i == 0) check("coin1 starts next cycle", coin_out[1], 1);
         if (coin_out[1]) h1++;
         if (coin_out[0]) h0++;
      end
      check("coin re-press pulse length", h1, PULSE);
      check("coin re-press other channel", h0, 0);

      // core_reset kills a pulse and discards edges
      coin_in[0] = 1'b1; tick(); coin_in[0] = 1'b0;
      check("coin0 pulse start", coin_out[0], 1);
      repeat (10) tick();
      user_reset = 1'b1; tick(); user_reset = 1'b0;
      check("reset core_reset", core_reset, 1);
      check("reset forces coin_out", coin_out, 0);
      tick(); tick();
      coin_in = 2'b11; tick(); tick(); coin_in = 2'b00;
      h0 = 0; n = 0;
      while (core_reset && n < 5000) begin
         tick(); n++;
         if (coin_out != 0) h0++;
      end
      check("coin during reset hold ends", core_reset, 0);
      repeat (100) begin tick(); if (coin_out != 0) h0++; end
      check("coin edge during reset discarded", h0, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
